// File: rtl/syn_branch_check_pkg.sv
// ============================================================================
// Module      : syn_branch_check_pkg
// Description : Shared types and constants for the EX-stage branch checker.
//               Supplies the IM_ADDR_BIT address-width fallback.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef IM_ADDR_BIT
`define IM_ADDR_BIT 32
`endif

package syn_branch_check_pkg;

    localparam int c_SHADOW_CNT_W = 3;

    typedef enum logic [0:0] {
        CHECK       = 1'b0,
        SHADOW_WAIT = 1'b1
    } bru_state_e;

endpackage

`default_nettype wire

// File: rtl/syn_bru_perf.sv
// ============================================================================
// Module      : syn_bru_perf
// Description : Saturating resolution / mispredict event counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module syn_bru_perf (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_br,
    input  logic        inc_mis,
    output logic [31:0] br_cnt,
    output logic [31:0] mis_cnt
);

    logic [31:0] r_br_cnt;
    logic [31:0] r_mis_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_br_cnt  <= '0;
            r_mis_cnt <= '0;
        end else begin
            if (inc_br && (r_br_cnt != '1)) begin
                r_br_cnt <= r_br_cnt + 32'd1;
            end
            if (inc_mis && (r_mis_cnt != '1)) begin
                r_mis_cnt <= r_mis_cnt + 32'd1;
            end
        end
    end

    assign br_cnt  = r_br_cnt;
    assign mis_cnt = r_mis_cnt;

endmodule

`default_nettype wire

// File: rtl/syn_branch_check.sv
// ============================================================================
// Module      : syn_branch_check
// Description : Resolves EX-stage branches against the fetched next-PC,
//               issues registered redirect/flush and shadows wrong-path slots.
//               Optional perf counters enabled by defining BRU_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef IM_ADDR_BIT
`define IM_ADDR_BIT 32
`endif

module syn_branch_check
    import syn_branch_check_pkg::*;
#(
    parameter int ADDR_W = `IM_ADDR_BIT,
    parameter int SHADOW = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              stall,
    input  logic              ex_valid,
    input  logic              ex_isbj,
    input  logic              ex_taken,
    input  logic [ADDR_W-1:0] ex_pc,
    input  logic [ADDR_W-1:0] ex_target,
    input  logic [ADDR_W-1:0] ex_pred,
    output logic              isbj,
    output logic              keep_pc,
    output logic              gone,
    output logic [ADDR_W-1:0] g_addr,
    output logic [ADDR_W-1:0] s_addr,
    output logic [ADDR_W-1:0] pc_before_g,
    output logic              flush
`ifdef BRU_PERF_CNT_EN
    ,
    output logic [31:0]       br_cnt,
    output logic [31:0]       mis_cnt
`endif
);

    localparam logic [c_SHADOW_CNT_W-1:0] c_SHADOW_LOAD = c_SHADOW_CNT_W'(SHADOW);

    bru_state_e                r_state;
    bru_state_e                w_state_nxt;
    logic [c_SHADOW_CNT_W-1:0] r_shadow_cnt;
    logic [c_SHADOW_CNT_W-1:0] w_shadow_cnt_nxt;

    logic              w_step;
    logic              w_resolve;
    logic              w_mispredict;
    logic [ADDR_W-1:0] w_seq_pc;
    logic [ADDR_W-1:0] w_actual;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= CHECK;
            r_shadow_cnt <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_shadow_cnt <= w_shadow_cnt_nxt;
        end
    end

    always_comb begin
        w_step           = en & ~stall;
        w_seq_pc         = ex_pc + ADDR_W'(1);
        w_actual         = ex_taken ? ex_target : w_seq_pc;
        w_resolve        = ex_valid & ex_isbj & w_step & (r_state == CHECK);
        w_mispredict     = w_resolve & (w_actual != ex_pred);
        w_state_nxt      = r_state;
        w_shadow_cnt_nxt = r_shadow_cnt;
        case (r_state)
            CHECK: begin
                if (w_mispredict) begin
                    w_state_nxt      = SHADOW_WAIT;
                    w_shadow_cnt_nxt = c_SHADOW_LOAD;
                end
            end
            SHADOW_WAIT: begin
                // Stalled slots do not retire a wrong-path instruction, so they don't count.
                if (w_step) begin
                    w_shadow_cnt_nxt = r_shadow_cnt - 1'b1;
                    if (r_shadow_cnt <= 1) begin
                        w_shadow_cnt_nxt = '0;
                        w_state_nxt      = CHECK;
                    end
                end
            end
            default: begin
                w_state_nxt      = CHECK;
                w_shadow_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            isbj        <= 1'b0;
            keep_pc     <= 1'b1;
            flush       <= 1'b0;
            gone        <= 1'b0;
            g_addr      <= '0;
            s_addr      <= '0;
            pc_before_g <= '0;
        end else if (en) begin
            isbj    <= w_resolve;
            flush   <= w_mispredict;
            keep_pc <= ~w_mispredict;
            // Redirect addresses and direction hold between resolutions.
            if (w_resolve) begin
                gone        <= ex_taken;
                g_addr      <= ex_target;
                s_addr      <= w_seq_pc;
                pc_before_g <= ex_pc;
            end
        end
    end

`ifdef BRU_PERF_CNT_EN
    syn_bru_perf u_perf (
        .clk     (clk),
        .rst     (rst),
        .inc_br  (w_resolve),
        .inc_mis (w_mispredict),
        .br_cnt  (br_cnt),
        .mis_cnt (mis_cnt)
    );
`endif

endmodule

`default_nettype wire

// File: tb/tb_syn_branch_check.sv
// ============================================================================
// Module      : tb_syn_branch_check
// Description : Directed + randomized self-checking bench for syn_branch_check.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_syn_branch_check;

    localparam int AW = 32;
    localparam int SH = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          en, stall, ex_valid, ex_isbj, ex_taken;
    logic [AW-1:0] ex_pc, ex_target, ex_pred;
    logic          isbj, keep_pc, gone, flush;
    logic [AW-1:0] g_addr, s_addr, pc_before_g;
`ifdef BRU_PERF_CNT_EN
    logic [31:0]   br_cnt, mis_cnt;
`endif

    syn_branch_check #(.ADDR_W(AW), .SHADOW(SH)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .stall       (stall),
        .ex_valid    (ex_valid),
        .ex_isbj     (ex_isbj),
        .ex_taken    (ex_taken),
        .ex_pc       (ex_pc),
        .ex_target   (ex_target),
        .ex_pred     (ex_pred),
        .isbj        (isbj),
        .keep_pc     (keep_pc),
        .gone        (gone),
        .g_addr      (g_addr),
        .s_addr      (s_addr),
        .pc_before_g (pc_before_g),
        .flush       (flush)
`ifdef BRU_PERF_CNT_EN
        ,
        .br_cnt      (br_cnt),
        .mis_cnt     (mis_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: expected output values and wrong-path slots still to discard.
    logic          e_isbj, e_keep, e_flush, e_gone;
    logic [AW-1:0] e_g, e_s, e_pcb;
    int            shadow_left;
    int            m_br, m_mis;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".isbj"},  64'(isbj),        64'(e_isbj));
        chk({tag, ".keep"},  64'(keep_pc),     64'(e_keep));
        chk({tag, ".flush"}, 64'(flush),       64'(e_flush));
        chk({tag, ".gone"},  64'(gone),        64'(e_gone));
        chk({tag, ".g"},     64'(g_addr),      64'(e_g));
        chk({tag, ".s"},     64'(s_addr),      64'(e_s));
        chk({tag, ".pcb"},   64'(pc_before_g), 64'(e_pcb));
    endtask

    task automatic model_reset();
        e_isbj = 1'b0; e_keep = 1'b1; e_flush = 1'b0; e_gone = 1'b0;
        e_g = '0; e_s = '0; e_pcb = '0;
        shadow_left = 0; m_br = 0; m_mis = 0;
    endtask

    // Asserted between clock edges so the asynchronous path is exercised.
    task automatic apply_reset(input string tag);
        rst = 1'b1;
        #2;
        model_reset();
        check_outputs(tag);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drive(input string tag, input logic d_en, input logic d_st,
                         input logic d_v, input logic d_bj, input logic d_tk,
                         input logic [AW-1:0] d_pc, input logic [AW-1:0] d_tg,
                         input logic [AW-1:0] d_pr);
        logic [AW-1:0] nxt;
        logic          res, mis;
        en = d_en; stall = d_st; ex_valid = d_v; ex_isbj = d_bj; ex_taken = d_tk;
        ex_pc = d_pc; ex_target = d_tg; ex_pred = d_pr;
        nxt = d_tk ? d_tg : d_pc + AW'(1);
        res = d_en && !d_st && d_v && d_bj && (shadow_left == 0);
        mis = res && (nxt != d_pr);
        if (d_en) begin
            e_isbj  = res;
            e_flush = mis;
            e_keep  = !mis;
            if (res) begin
                e_gone = d_tk; e_g = d_tg; e_s = d_pc + AW'(1); e_pcb = d_pc;
                m_br++;
                if (mis) m_mis++;
            end
            if (mis) shadow_left = SH;
            else if (!d_st && shadow_left > 0) shadow_left--;
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic idle(input string tag);
        drive(tag, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    initial begin
        logic [AW-1:0] pc, tg, pr, ones;
        logic          tk;
        ones = '1;
        en = 1'b0; stall = 1'b0; ex_valid = 1'b0; ex_isbj = 1'b0; ex_taken = 1'b0;
        ex_pc = '0; ex_target = '0; ex_pred = '0;
        #3;
        apply_reset("reset");
        idle("idle0");

        // Correctly predicted taken branch.
        drive("taken_ok", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h10, 32'h40, 32'h40);
        idle("taken_ok_after");
        // Not-taken mispredict followed by two shadowed branches, then a live one.
        drive("nt_mis", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h40, 32'h40);
        drive("shadow1", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h20, 32'h80, 32'h21);
        drive("shadow2", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h21, 32'h80, 32'h22);
        drive("post_shadow", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h30, 32'h90, 32'h31);
        // Sequential-address wrap.
        drive("wrap", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, ones, 32'h5, 32'h0);
        // Non-branch instruction is silent.
        drive("nonbr", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h50, 32'h99, 32'h0);
        // Mispredict held off by a 3-cycle stall, then one flush pulse.
        for (int i = 0; i < 3; i++)
            drive("stall_mis", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h60, 32'h70, 32'h61);
        drive("stall_release", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h60, 32'h70, 32'h61);
        // Stall inside the shadow freezes it; en low freezes everything.
        drive("sh_stall", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h62, 32'h0, 32'h0);
        drive("sh_en_lo", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h63, 32'h0, 32'h0);
        drive("sh_step1", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h64, 32'h0, 32'h0);
        drive("sh_step2", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h65, 32'h0, 32'h0);
        drive("sh_done", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h66, 32'h0, 32'h67);

        // Reset inside the shadow, then a mispredict must flush immediately.
        drive("pre_rst_mis", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h100, 32'h200, 32'h101);
        apply_reset("rst_in_shadow");
        drive("post_rst_mis", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h110, 32'h0, 32'h300);

`ifdef BRU_PERF_CNT_EN
        apply_reset("perf_rst");
        drive("pc1", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h10, 32'h40, 32'h40);
        drive("pc2", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h20, 32'h40, 32'h21);
        drive("pc3", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h30, 32'h40, 32'h99);
        for (int i = 0; i < SH; i++) idle("pc_gap");
        drive("pc4", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h40, 32'h80, 32'h41);
        for (int i = 0; i < SH; i++) idle("pc_gap");
        drive("pc5", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h50, 32'h90, 32'h90);
        chk("br_cnt5", 64'(br_cnt), 64'd5);
        chk("mis_cnt2", 64'(mis_cnt), 64'd2);
`endif

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                apply_reset("rand_rst");
            end else begin
                pc = ($urandom_range(0, 15) == 0) ? ones : AW'($urandom);
                tg = AW'($urandom);
                tk = 1'($urandom);
                case ($urandom_range(0, 3))
                    0, 1:    pr = tk ? tg : pc + AW'(1);
                    2:       pr = tk ? pc + AW'(1) : tg;
                    default: pr = AW'($urandom);
                endcase
                drive("rand", ($urandom_range(0, 9) != 0), ($urandom_range(0, 4) == 0),
                      ($urandom_range(0, 4) != 0), ($urandom_range(0, 9) < 7), tk, pc, tg, pr);
            end
        end

`ifdef BRU_PERF_CNT_EN
        chk("br_cnt_end", 64'(br_cnt), 64'(m_br));
        chk("mis_cnt_end", 64'(mis_cnt), 64'(m_mis));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
